imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate-extension unit for the datapath. It widens an IN_W-bit immediate to OUT_W bits under a per-transaction mode: zero-extend, sign-extend, sign-extend-and-shift (branch offsets), or sign-extend-and-negate. It sits between the decode stage and the ALU operand mux. Both sides use valid/ready handshakes, and a 2-entry skid buffer keeps in_ready a pure register output.

---
 rtl/imm_extend_pipe.sv | 120 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Pipelined immediate-extension unit between decode and the ALU operand mux.
//   Widens an IN_W-bit immediate to OUT_W bits according to a per-item mode
//   and carries a sideband tag alongside the result. A two-entry buffer
//   (output register plus skid register) lets in_ready come straight from a
//   flop, so there is no combinational path from out_ready back to in_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all buffered entries
//   in_valid   input item valid
//   in_ready   unit can accept an input this cycle (registered)
//   in_data    raw immediate, IN_W bits
//   in_mode    00 zero-ext, 01 sign-ext, 10 sign-ext << SHIFT, 11 -sign-ext
//   in_tag     sideband tag, TAG_W bits
//   out_valid  output item valid
//   out_ready  consumer accepts output this cycle
//   out_data   extended result, OUT_W bits
//   out_tag    tag matching out_data
module imm_extend_pipe #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 8,
  parameter int SHIFT = 1,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_result;
  logic             w_accept;
  logic             w_drain;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;

  // Extension is done on the incoming immediate so only finished results are
  // ever buffered. Parameter constraints leave room for the shift and the
  // negation of the most negative input, so nothing overflows.
  always_comb begin
    w_zext   = {{(OUT_W-IN_W){1'b0}}, in_data};
    w_sext   = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
    w_result = w_zext;
    case (in_mode)
      2'b00:   w_result = w_zext;
      2'b01:   w_result = w_sext;
      2'b10:   w_result = w_sext << SHIFT;
      2'b11:   w_result = '0 - w_sext;
      default: w_result = w_zext;
    endcase
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  // Occupancy is encoded by the two valid bits: EMPTY (neither), ONE (output
  // only), FULL (both). The skid only fills when the output register is
  // occupied and not draining, and it always refills the output register
  // first, which keeps items in FIFO order. in_ready is tracked as its own
  // flop, always the inverse of the skid valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_tag    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_tag   <= '0;
    end else if (flush) begin
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (w_drain) begin
        r_out_data   <= r_skid_data;
        r_out_tag    <= r_skid_tag;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (!r_out_valid || w_drain) begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_tag   <= in_tag;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_result;
      r_skid_tag   <= in_tag;
      r_in_ready   <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Self-checking bench for imm_extend_pipe. A queue of expected results
//   models the buffer: each accepted item is pushed with its value computed
//   by plain signed arithmetic, each drain pops the head, and flush or reset
//   empties it. Directed steps cover the worked examples, back-pressure,
//   flush and asynchronous reset, followed by a randomized phase. A second
//   instance with wider parameters checks the parametric example.
module tb_imm_extend_pipe;

  localparam int IN_W  = 2;
  localparam int OUT_W = 8;
  localparam int SHIFT = 1;
  localparam int TAG_W = 3;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } item_t;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  logic             wFlush;
  logic             wInValid;
  logic             wInReady;
  logic [4:0]       wInData;
  logic [1:0]       wInMode;
  logic [3:0]       wInTag;
  logic             wOutValid;
  logic             wOutReady;
  logic [15:0]      wOutData;
  logic [3:0]       wOutTag;

  int compared;
  int mismatched;
  item_t expQ[$];

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  imm_extend_pipe #(.IN_W(5), .OUT_W(16), .SHIFT(2), .TAG_W(4)) dutWide (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (wFlush),
    .in_valid  (wInValid),
    .in_ready  (wInReady),
    .in_data   (wInData),
    .in_mode   (wInMode),
    .in_tag    (wInTag),
    .out_valid (wOutValid),
    .out_ready (wOutReady),
    .out_data  (wOutData),
    .out_tag   (wOutTag)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference value: interpret the immediate as an integer, then apply the
  // mode arithmetically and reduce modulo 2^OUT_W.
  function automatic logic [OUT_W-1:0] refValue(input logic [IN_W-1:0] d, input logic [1:0] m);
    longint v;
    v = longint'(d);
    if (m != 2'b00 && v >= (longint'(1) << (IN_W-1))) v = v - (longint'(1) << IN_W);
    if (m == 2'b10) v = v * (longint'(1) << SHIFT);
    if (m == 2'b11) v = -v;
    return OUT_W'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d, input logic [1:0] m,
                               input logic [TAG_W-1:0] t);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
  endtask

  // One clock cycle: resolve handshakes from the values set up before the
  // edge, update the model, then check the DUT state at the next falling edge.
  task automatic cycle();
    logic  acc;
    logic  drn;
    item_t it;
    acc = in_valid & in_ready;
    drn = out_valid & out_ready;
    if (drn) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        it = expQ.pop_front();
        checkOutput("drain_data", 32'(out_data), 32'(it.data));
        checkOutput("drain_tag", 32'(out_tag), 32'(it.tag));
      end
    end
    if (flush) begin
      expQ.delete();
    end else if (acc) begin
      it.data = refValue(in_data, in_mode);
      it.tag  = in_tag;
      expQ.push_back(it);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() > 0));
    checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() < 2));
    if (expQ.size() > 0) begin
      checkOutput("head_data", 32'(out_data), 32'(expQ[0].data));
      checkOutput("head_tag", 32'(out_tag), 32'(expQ[0].tag));
    end
  endtask

  // Send a single item with out_ready=1, check the literal expected value,
  // then let it drain.
  task automatic sendOne(input logic [IN_W-1:0] d, input logic [1:0] m, input logic [TAG_W-1:0] t,
                         input logic [OUT_W-1:0] lit, input string name);
    out_ready = 1'b1;
    applyStimulus(1'b1, d, m, t);
    cycle();
    applyStimulus(1'b0, '0, 2'b00, '0);
    checkOutput(name, 32'(out_data), 32'(lit));
    checkOutput({name, "_tag"}, 32'(out_tag), 32'(t));
    cycle();
  endtask

  initial begin
    logic holding;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    applyStimulus(1'b0, '0, 2'b00, '0);
    wFlush    = 1'b0;
    wInValid  = 1'b0;
    wInData   = '0;
    wInMode   = 2'b00;
    wInTag    = '0;
    wOutReady = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed mode examples");
    sendOne(2'b10, 2'b01, 3'd5, 8'hFE, "m01_10");
    sendOne(2'b00, 2'b01, 3'd1, 8'h00, "m01_00");
    sendOne(2'b01, 2'b01, 3'd2, 8'h01, "m01_01");
    sendOne(2'b11, 2'b01, 3'd3, 8'hFF, "m01_11");
    sendOne(2'b10, 2'b00, 3'd4, 8'h02, "m00_10");
    sendOne(2'b11, 2'b10, 3'd6, 8'hFE, "m10_11");
    sendOne(2'b01, 2'b10, 3'd7, 8'h02, "m10_01");
    sendOne(2'b10, 2'b11, 3'd0, 8'h02, "m11_10");
    sendOne(2'b01, 2'b11, 3'd5, 8'hFF, "m11_01");

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b01, 2'b01, 3'd1);
    cycle();
    applyStimulus(1'b1, 2'b10, 2'b01, 3'd2);
    cycle();
    applyStimulus(1'b0, '0, 2'b00, '0);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_data", 32'(out_data), 32'h01);
    cycle();
    checkOutput("bp_still_hold", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    cycle();
    checkOutput("bp_second_data", 32'(out_data), 32'hFE);
    checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
    cycle();

    $display("[TB] streaming");
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, IN_W'($urandom), 2'($urandom), TAG_W'(i));
      cycle();
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
    end
    applyStimulus(1'b0, '0, 2'b00, '0);
    cycle();

    $display("[TB] flush from full");
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b01, 2'b00, 3'd3);
    cycle();
    applyStimulus(1'b1, 2'b11, 2'b11, 3'd4);
    cycle();
    flush = 1'b1;
    applyStimulus(1'b1, 2'b10, 2'b10, 3'd5);
    cycle();
    flush = 1'b0;
    applyStimulus(1'b0, '0, 2'b00, '0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    cycle();
    sendOne(2'b11, 2'b00, 3'd6, 8'h03, "post_flush");

    $display("[TB] asynchronous reset");
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b10, 2'b01, 3'd7);
    cycle();
    applyStimulus(1'b0, '0, 2'b00, '0);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_out_data", 32'(out_data), 32'd0);
    checkOutput("arst_out_tag", 32'(out_tag), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    expQ.delete();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    sendOne(2'b10, 2'b01, 3'd5, 8'hFE, "recover_m01_10");

    $display("[TB] wide parameter set");
    wInValid = 1'b1;
    wInData  = 5'b10000;
    wInMode  = 2'b10;
    wInTag   = 4'd9;
    @(posedge clk);
    @(negedge clk);
    wInValid = 1'b0;
    checkOutput("wide_valid", 32'(wOutValid), 32'd1);
    checkOutput("wide_m10", 32'(wOutData), 32'hFFC0);
    checkOutput("wide_tag", 32'(wOutTag), 32'd9);
    wInValid = 1'b1;
    wInData  = 5'b00001;
    wInMode  = 2'b11;
    @(posedge clk);
    @(negedge clk);
    wInValid = 1'b0;
    checkOutput("wide_m11", 32'(wOutData), 32'hFFFF);
    @(posedge clk);
    @(negedge clk);
    checkOutput("wide_empty", 32'(wOutValid), 32'd0);

    $display("[TB] randomized traffic");
    holding = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!holding) begin
        applyStimulus(1'($urandom_range(0, 1)), IN_W'($urandom), 2'($urandom), TAG_W'($urandom));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      holding   = in_valid & ~in_ready & ~flush;
      cycle();
    end
    flush = 1'b0;
    applyStimulus(1'b0, '0, 2'b00, '0);
    out_ready = 1'b1;
    repeat (3) cycle();
    checkOutput("final_empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
